ififo_bank: RTL

IFIFO_BANK -- requirements
Module: ififo_bank

---
 rtl/ififo_bank.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ififo_bank.sv
// ififo_bank: a bank of ROW independent input FIFOs. It feeds the west edge of
// the MAC array.
// A single rd request starts a pop wave across all lanes. Each lane pops its
// head word into a registered out lane and pulses o_valid for that lane.
// Optional macro IFIFO_BANK_SKEW_EN: lane i pops i cycles after lane 0, which
// gives a diagonal feed. When the macro is undefined, all lanes pop together.
module ififo_bank #(
  parameter int ROW   = 8,
  parameter int BW    = 4,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROW*BW-1:0] in,
  input  logic [ROW-1:0]    wr,
  input  logic              rd,
  output logic [ROW*BW-1:0] out,
  output logic [ROW-1:0]    o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ROW-1:0] pop_req;
  logic [ROW-1:0] lane_full;
  logic [ROW-1:0] lane_empty;
  logic [ROW-1:0] pop_fire;
  logic [ROW-1:0] wr_fire;
  logic [ROW-1:0] wr_drop;
  logic [ROW-1:0] pop_drop;

`ifdef IFIFO_BANK_SKEW_EN
  logic [ROW-1:0] pop_sr;

  // Pop-wave shift register: stage i holds the lane-i pop request, so each rd
  // pulse ripples diagonally across the lanes, and overlapping waves stay apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_sr <= '0;
    end else begin
      pop_sr[0] <= rd;
      for (int i = 1; i < ROW; i++) pop_sr[i] <= pop_sr[i-1];
    end
  end

  assign pop_req = pop_sr;
`else
  logic pop_q;

  // Single-stage pop request that is shared by every lane.
  always_ff @(posedge clk) begin
    if (reset) pop_q <= 1'b0;
    else       pop_q <= rd;
  end

  assign pop_req = {ROW{pop_q}};
`endif

  for (genvar g = 0; g < ROW; g++) begin : g_lane
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [BW-1:0] mem [DEPTH];
    logic [BW-1:0] out_q;
    logic          valid_q;

    assign lane_empty[g] = (wr_ptr == rd_ptr);
    assign lane_full[g]  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // A full lane can still accept a write when it pops in the same cycle.
    assign pop_fire[g]   = pop_req[g] & ~lane_empty[g];
    assign wr_fire[g]    = wr[g] & (~lane_full[g] | pop_fire[g]);
    assign wr_drop[g]    = wr[g] & lane_full[g] & ~pop_fire[g];
    assign pop_drop[g]   = pop_req[g] & lane_empty[g];

    // Pointer advance, and the registered head word with its one-cycle valid strobe.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= pop_fire[g];
        if (wr_fire[g]) wr_ptr <= wr_ptr + 1'b1;
        if (pop_fire[g]) begin
          rd_ptr <= rd_ptr + 1'b1;
          out_q  <= mem[rd_ptr[AW-1:0]];
        end
      end
    end

    // Storage is not reset. Emptiness comes from the current pointers, so a
    // word written in this cycle cannot be popped until the next edge.
    always_ff @(posedge clk) begin
      if (!reset && wr_fire[g]) mem[wr_ptr[AW-1:0]] <= in[g*BW +: BW];
    end

    assign out[g*BW +: BW] = out_q;
    assign o_valid[g]      = valid_q;
  end

  // Sticky error flags for dropped writes and dropped pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (|wr_drop)  o_overflow  <= 1'b1;
      if (|pop_drop) o_underflow <= 1'b1;
    end
  end

  assign o_full  = |lane_full;
  assign o_ready = ~o_full;
  assign o_empty = |lane_empty;

endmodule
